mma7660_i2c_slave: RTL and testbench

Synthesizable I2C responder that emulates the MMA7660 accelerometer register interface on the system clock. It answers device address 0x4C (write byte 0x98, read byte 0x99), keeps a small register file with X/Y/Z sample snapshots and a MODE register, and is used as the bus-functional counterpart of the team's MMA7660 master in simulation and FPGA loopback builds.

---
 rtl/mma7660_i2c_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_mma7660_i2c_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mma7660_i2c_slave.sv
// rtl/mma7660_i2c_slave.sv - MMA7660 accelerometer register-file I2C responder on the system clock
// Define MMA_SLAVE_AUTOINC_EN to auto-increment the register pointer on burst reads and writes.
module mma7660_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h4C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] xin,
  input  logic [7:0] yin,
  input  logic [7:0] zin,
  input  logic       sample_valid,
  output logic [7:0] mode,
  output logic       busy,
  output logic       wr_pulse
);

`ifdef MMA_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_MACK
  } state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       sda_oe, rw, phase, pending;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh, tx_sh;
  logic [3:0] ptr;
  logic [7:0] sr, x_reg, y_reg, z_reg, px, py, pz, rd_byte;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] rx_byte;
  logic [3:0] ptr_inc;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {rx_sh, sda_s};
  assign last_bit  = scl_rise && (bit_cnt == 3'd7);
  assign ptr_inc   = (ptr >= 4'hA) ? 4'h0 : ptr + 4'h1;

  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      4'h0:    rd_byte = x_reg;
      4'h1:    rd_byte = y_reg;
      4'h2:    rd_byte = z_reg;
      4'h7:    rd_byte = mode;
      4'h8:    rd_byte = sr;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      mode     <= 8'h00;
      sr       <= 8'h00;
      ptr      <= 4'h0;
      rx_sh    <= 7'h00;
      tx_sh    <= 7'h00;
      bit_cnt  <= 3'd0;
      phase    <= 1'b0;
      rw       <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        phase  <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= 3'd0;
        phase   <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (last_bit) begin
              if (state == ST_ADDR) begin
                if (rx_sh == DEV_ADDR) begin
                  rw    <= sda_s;
                  state <= ST_ADDR_ACK;
                end else begin
                  state <= ST_IDLE;
                end
              end else if (state == ST_PTR) begin
                ptr   <= rx_byte[3:0];
                state <= ST_PTR_ACK;
              end else begin
                if (ptr == 4'h7) mode <= rx_byte;
                else if (ptr == 4'h8) sr <= rx_byte;
                wr_pulse <= 1'b1;
                if (AUTOINC) ptr <= ptr_inc;
                state <= ST_WDATA_ACK;
              end
            end
          end
          // phase 0: 8th falling edge starts the ACK; phase 1: 9th falling edge ends it
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                if (state == ST_ADDR_ACK && rw) begin
                  tx_sh  <= rd_byte[6:0];
                  sda_oe <= ~rd_byte[7];
                  state  <= ST_RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b0;
                phase  <= 1'b0;
                state  <= ST_MACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                sda_oe  <= ~tx_sh[6];
                tx_sh   <= {tx_sh[5:0], 1'b0};
              end
            end
          end
          ST_MACK: begin
            if (scl_rise && !phase) begin
              if (sda_s) begin
                state <= ST_IDLE;
              end else begin
                phase <= 1'b1;
                if (AUTOINC) ptr <= ptr_inc;
              end
            end else if (scl_fall && phase) begin
              phase   <= 1'b0;
              bit_cnt <= 3'd0;
              tx_sh   <= rd_byte[6:0];
              sda_oe  <= ~rd_byte[7];
              state   <= ST_RDATA;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Snapshots requested while the bus is busy wait in px/py/pz until after STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= 8'h00;
      y_reg   <= 8'h00;
      z_reg   <= 8'h00;
      px      <= 8'h00;
      py      <= 8'h00;
      pz      <= 8'h00;
      pending <= 1'b0;
    end else if (sample_valid && mode[0]) begin
      if (busy) begin
        px      <= xin;
        py      <= yin;
        pz      <= zin;
        pending <= 1'b1;
      end else begin
        x_reg   <= xin;
        y_reg   <= yin;
        z_reg   <= zin;
        pending <= 1'b0;
      end
    end else if (pending && !busy) begin
      x_reg   <= px;
      y_reg   <= py;
      z_reg   <= pz;
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mma7660_i2c_slave.sv
// tb/tb_mma7660_i2c_slave.sv - scoreboard bench for the MMA7660 I2C responder
module tb_mma7660_i2c_slave;
  localparam int Q = 50;

`ifdef MMA_SLAVE_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  wire        sda;
  logic       m_sda_low;
  logic [7:0] xin, yin, zin;
  logic       sample_valid;
  logic [7:0] mode;
  logic       busy, wr_pulse;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  mma7660_i2c_slave dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl          (scl),
    .sda          (sda),
    .xin          (xin),
    .yin          (yin),
    .zin          (zin),
    .sample_valid (sample_valid),
    .mode         (mode),
    .busy         (busy),
    .wr_pulse     (wr_pulse)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    wr_cnt      = 0;
  logic  watch_low   = 1'b0;
  logic  saw_low     = 1'b0;

  task automatic exp_push(input string n, input logic [7:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic obs_push(input string n, input logic [7:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    obs_q.push_back(it);
  endtask

  task automatic chk(input string n, input logic [7:0] want, input logic [7:0] got);
    exp_push(n, want);
    obs_push(n, got);
  endtask

  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      item_t o;
      item_t e;
      o = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s: got %02h, nothing expected", o.name, o.val);
      end else begin
        e = exp_q.pop_front();
        if (e.name != o.name || o.val !== e.val) begin
          miscompares++;
          $display("FAIL %s: got %02h (%s), want %02h", e.name, o.val, o.name, e.val);
        end
      end
    end
  end

  always @(negedge clk) if (wr_pulse) wr_cnt++;
  always @(posedge clk) if (watch_low && !m_sda_low && sda === 1'b0) saw_low = 1'b1;

  task automatic i2c_start();
    if (scl === 1'b0) begin
      #Q; m_sda_low = 1'b0; #Q; scl = 1'b1; #Q;
    end else begin
      m_sda_low = 1'b0; #Q;
    end
    m_sda_low = 1'b1; #Q;
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q; m_sda_low = 1'b1; #Q; scl = 1'b1; #Q; m_sda_low = 1'b0; #(2*Q);
  endtask

  task automatic wr_byte(input string n, input logic [7:0] b, input logic exp_nack);
    exp_push(n, {7'd0, exp_nack});
    for (int i = 7; i >= 0; i--) begin
      #Q; m_sda_low = ~b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
    end
    #Q; m_sda_low = 1'b0; #Q; scl = 1'b1; #Q;
    obs_push(n, {7'd0, sda});
    #Q; scl = 1'b0;
  endtask

  task automatic rd_byte(input string n, input logic [7:0] want, input logic mack);
    logic [7:0] b;
    exp_push(n, want);
    for (int i = 7; i >= 0; i--) begin
      #Q; m_sda_low = 1'b0; #Q; scl = 1'b1; #Q; b[i] = sda; #Q; scl = 1'b0;
    end
    obs_push(n, b);
    #Q; m_sda_low = mack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
  endtask

  task automatic snap(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    @(negedge clk);
    xin = x; yin = y; zin = z; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic open_read(input string n, input logic [7:0] p);
    i2c_start();
    wr_byte({n, "_aw"}, 8'h98, 1'b0);
    wr_byte({n, "_ptr"}, p, 1'b0);
    i2c_start();
    wr_byte({n, "_ar"}, 8'h99, 1'b0);
  endtask

  task automatic write_reg(input string n, input logic [7:0] p, input logic [7:0] d);
    i2c_start();
    wr_byte({n, "_aw"}, 8'h98, 1'b0);
    wr_byte({n, "_ptr"}, p, 1'b0);
    wr_byte({n, "_dat"}, d, 1'b0);
    i2c_stop();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int w0;
    rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
    xin = 8'h00; yin = 8'h00; zin = 8'h00; sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mode", 8'h00, mode);
    chk("rst_busy", 8'h00, {7'd0, busy});
    chk("rst_wr_pulse", 8'h00, {7'd0, wr_pulse});
    chk("rst_sda", 8'h01, {7'd0, sda});
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // MODE write
    w0 = wr_cnt;
    i2c_start();
    chk("t1_busy_mid", 8'h01, {7'd0, busy});
    wr_byte("t1_aw", 8'h98, 1'b0);
    wr_byte("t1_ptr", 8'h07, 1'b0);
    wr_byte("t1_dat", 8'h01, 1'b0);
    i2c_stop();
    chk("t1_mode", 8'h01, mode);
    chk("t1_busy_after", 8'h00, {7'd0, busy});
    chk("t1_wr_pulses", 8'd1, 8'(wr_cnt - w0));

    // snapshot then 3-byte burst read
    snap(8'h12, 8'h34, 8'h05);
    open_read("t2", 8'h00);
    rd_byte("t2_b0", 8'h12, 1'b1);
    rd_byte("t2_b1", AUTO ? 8'h34 : 8'h12, 1'b1);
    rd_byte("t2_b2", AUTO ? 8'h05 : 8'h12, 1'b0);
    i2c_stop();

    // wrong device address
    w0 = wr_cnt; saw_low = 1'b0; watch_low = 1'b1;
    i2c_start();
    wr_byte("t3_aw", 8'h9A, 1'b1);
    wr_byte("t3_ptr", 8'h07, 1'b1);
    wr_byte("t3_dat", 8'h00, 1'b1);
    i2c_stop();
    watch_low = 1'b0;
    chk("t3_sda_driven", 8'h00, {7'd0, saw_low});
    chk("t3_mode", 8'h01, mode);
    chk("t3_wr_pulses", 8'd0, 8'(wr_cnt - w0));

    // snapshot request after the read byte is loaded
    open_read("t4", 8'h00);
    snap(8'h20, 8'h21, 8'h22);
    rd_byte("t4_b0", 8'h12, 1'b0);
    #Q; m_sda_low = 1'b1; #Q; scl = 1'b1; #Q; m_sda_low = 1'b0;
    for (int n = 0; n < 20 && busy !== 1'b0; n++) @(negedge clk);
    chk("t4_busy_fall", 8'h00, {7'd0, busy});
    chk("t4_x_at_stop", 8'h12, dut.x_reg);
    @(negedge clk);
    chk("t4_x_after_stop", 8'h20, dut.x_reg);
    #(2*Q);

    // reset in the 5th bit of a read byte (X=0x20, bit 3 is 0)
    open_read("t5", 8'h00);
    for (int i = 0; i < 4; i++) begin
      #Q; m_sda_low = 1'b0; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
    end
    #Q; #Q; scl = 1'b1; #Q;
    chk("t5_bit5_low", 8'h00, {7'd0, sda});
    rst_n = 1'b0;
    #1;
    chk("t5_sda_released", 8'h01, {7'd0, sda});
    chk("t5_mode", 8'h00, mode);
    chk("t5_busy", 8'h00, {7'd0, busy});
    chk("t5_x", 8'h00, dut.x_reg);
    chk("t5_ptr", 8'h00, {4'd0, dut.ptr});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    write_reg("t5w", 8'h07, 8'h01);
    chk("t5_mode_after", 8'h01, mode);

    // write burst across the 0x0A wrap
    snap(8'h12, 8'h34, 8'h05);
    w0 = wr_cnt;
    i2c_start();
    wr_byte("t6_aw", 8'h98, 1'b0);
    wr_byte("t6_ptr", 8'h0A, 1'b0);
    wr_byte("t6_d0", 8'h55, 1'b0);
    wr_byte("t6_d1", 8'h66, 1'b0);
    i2c_stop();
    chk("t6_wr_pulses", 8'd2, 8'(wr_cnt - w0));
    chk("t6_mode", 8'h01, mode);
    i2c_start();
    wr_byte("t6_ar", 8'h99, 1'b0);
    rd_byte("t6_rd_wrap", AUTO ? 8'h34 : 8'h00, 1'b0);
    i2c_stop();
    open_read("t6x", 8'h00);
    rd_byte("t6_x_kept", 8'h12, 1'b0);
    i2c_stop();

    // SR read-back, MODE read, unmapped address
    write_reg("t7w", 8'h08, 8'hA5);
    open_read("t7s", 8'h08);
    rd_byte("t7_sr", 8'hA5, 1'b0);
    i2c_stop();
    open_read("t7m", 8'h07);
    rd_byte("t7_mode", 8'h01, 1'b0);
    i2c_stop();
    open_read("t7u", 8'h0C);
    rd_byte("t7_unmapped", 8'h00, 1'b0);
    i2c_stop();

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d expected and %0d observed left, want 0 and 0",
               exp_q.size(), obs_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
